// File: rtl/mem_req_arbiter_pkg.sv
// rtl/mem_req_arbiter_pkg.sv - shared widths, FSM state and owner encoding for the memory request arbiter
package mem_req_arbiter_pkg;

   localparam int ADDR_WIDTH_DEF         = 32;
   localparam int WORD_WIDTH_DEF         = 32;
   localparam int ICACHE_DATA_BLOCK_SIZE = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWNER_LSU = 1'b0,
      OWNER_IFU = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_req_arbiter_arb2_rr.sv
// rtl/mem_req_arbiter_arb2_rr.sv - two-way round-robin grant; req/grant bit 0 = LSU, bit 1 = IFU
module arb2_rr (
   input  logic       clk,
   input  logic       rst_aL,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   // 1 = IFU was granted last, so LSU wins the first conflict after reset
   logic last_grant;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         last_grant <= 1'b1;
      end else if (advance) begin
         last_grant <= grant[1];
      end
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - single-outstanding arbiter between IFU fills and LSU accesses onto main memory
module mem_req_arbiter
   import mem_req_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int WORD_WIDTH = WORD_WIDTH_DEF,
   parameter int BLOCK_BITS = ICACHE_DATA_BLOCK_SIZE
) (
   input  logic                  clk,
   input  logic                  rst_aL,
   input  logic                  ifu_req_valid,
   output logic                  ifu_req_ready,
   input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
   input  logic                  ifu_flush,
   input  logic                  lsu_req_valid,
   output logic                  lsu_req_ready,
   input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
   input  logic                  lsu_req_is_st,
   input  logic [2:0]            lsu_req_size,
   input  logic [WORD_WIDTH-1:0] lsu_req_data,
   output logic                  mem_send_en,
   input  logic                  mem_ready,
   output logic                  mem_send_lsu_aL_ifu_aH,
   output logic [ADDR_WIDTH-1:0] mem_send_addr,
   output logic [2:0]            mem_send_size,
   output logic [WORD_WIDTH-1:0] mem_send_data,
   input  logic                  mem_recv_valid,
   input  logic [BLOCK_BITS-1:0] mem_recv_data,
   output logic                  ifu_resp_valid,
   output logic                  lsu_resp_valid,
   output logic [BLOCK_BITS-1:0] resp_data
);

   arb_state_e            state, state_nxt;
   owner_e                owner;
   logic                  drop, drop_nxt;
   logic                  req_is_st;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [2:0]            req_size;
   logic [WORD_WIDTH-1:0] req_data;
   logic [1:0]            req, grant;
   logic                  grant_fire;
   logic                  ifu_owned_flush;
   logic                  recv_in_wait;

   assign req        = (state == ST_IDLE) ? {ifu_req_valid, lsu_req_valid} : 2'b00;
   assign grant_fire = |grant;

   arb2_rr u_arb2_rr (
      .clk     (clk),
      .rst_aL  (rst_aL),
      .req     (req),
      .advance (grant_fire),
      .grant   (grant)
   );

   assign ifu_owned_flush = ifu_flush && (owner == OWNER_IFU);

   always_comb begin
      state_nxt = state;
      drop_nxt  = drop;
      case (state)
         ST_IDLE: begin
            if (grant_fire) state_nxt = ST_SEND;
         end
         ST_SEND: begin
            if (mem_ready) begin
               // a store is fire-and-forget; a flush on the accept beat drops the response instead
               if (owner == OWNER_LSU && req_is_st) begin
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_WAIT;
                  drop_nxt  = ifu_owned_flush;
               end
            end else if (ifu_owned_flush) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (mem_recv_valid) begin
               state_nxt = ST_IDLE;
               drop_nxt  = 1'b0;
            end else if (ifu_owned_flush) begin
               drop_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            drop_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         state <= ST_IDLE;
         drop  <= 1'b0;
      end else begin
         state <= state_nxt;
         drop  <= drop_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         owner     <= OWNER_LSU;
         req_is_st <= 1'b0;
         req_addr  <= '0;
         req_size  <= '0;
         req_data  <= '0;
      end else if (grant_fire) begin
         owner     <= grant[1] ? OWNER_IFU : OWNER_LSU;
         req_is_st <= grant[0] & lsu_req_is_st;
         req_addr  <= grant[1] ? ifu_req_addr : lsu_req_addr;
         req_size  <= grant[1] ? 3'b000 : lsu_req_size;
         req_data  <= grant[1] ? '0 : lsu_req_data;
      end
   end

   assign recv_in_wait = (state == ST_WAIT) && mem_recv_valid;

   // readies and the response bus are forced low while reset is held
   assign ifu_req_ready          = rst_aL && grant[1];
   assign lsu_req_ready          = rst_aL && grant[0];
   assign mem_send_en            = (state == ST_SEND);
   assign mem_send_lsu_aL_ifu_aH = (owner == OWNER_IFU);
   assign mem_send_addr          = req_addr;
   assign mem_send_size          = req_size;
   assign mem_send_data          = req_data;
   assign ifu_resp_valid         = recv_in_wait && (owner == OWNER_IFU) && !drop && !ifu_flush;
   assign lsu_resp_valid         = recv_in_wait && (owner == OWNER_LSU);
   assign resp_data              = rst_aL ? mem_recv_data : '0;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - self-checking bench for mem_req_arbiter with a transaction-level reference model
module tb_mem_req_arbiter;

   logic        clk = 1'b0;
   logic        rst_aL = 1'b0;
   logic        ifu_req_valid = 1'b0;
   logic        ifu_req_ready;
   logic [31:0] ifu_req_addr = '0;
   logic        ifu_flush = 1'b0;
   logic        lsu_req_valid = 1'b0;
   logic        lsu_req_ready;
   logic [31:0] lsu_req_addr = '0;
   logic        lsu_req_is_st = 1'b0;
   logic [2:0]  lsu_req_size = '0;
   logic [31:0] lsu_req_data = '0;
   logic        mem_send_en;
   logic        mem_ready = 1'b0;
   logic        mem_send_lsu_aL_ifu_aH;
   logic [31:0] mem_send_addr;
   logic [2:0]  mem_send_size;
   logic [31:0] mem_send_data;
   logic        mem_recv_valid = 1'b0;
   logic [63:0] mem_recv_data = '0;
   logic        ifu_resp_valid;
   logic        lsu_resp_valid;
   logic [63:0] resp_data;

   int checks = 0;
   int errors = 0;
   bit m_last_ifu = 1'b1;

   always #5 clk = ~clk;

   mem_req_arbiter #(.ADDR_WIDTH(32), .WORD_WIDTH(32), .BLOCK_BITS(64)) dut (
      .clk(clk), .rst_aL(rst_aL),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
      .ifu_req_addr(ifu_req_addr), .ifu_flush(ifu_flush),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
      .lsu_req_addr(lsu_req_addr), .lsu_req_is_st(lsu_req_is_st),
      .lsu_req_size(lsu_req_size), .lsu_req_data(lsu_req_data),
      .mem_send_en(mem_send_en), .mem_ready(mem_ready),
      .mem_send_lsu_aL_ifu_aH(mem_send_lsu_aL_ifu_aH), .mem_send_addr(mem_send_addr),
      .mem_send_size(mem_send_size), .mem_send_data(mem_send_data),
      .mem_recv_valid(mem_recv_valid), .mem_recv_data(mem_recv_data),
      .ifu_resp_valid(ifu_resp_valid), .lsu_resp_valid(lsu_resp_valid),
      .resp_data(resp_data)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ifu_req_valid = 0; ifu_flush = 0; lsu_req_valid = 0; lsu_req_is_st = 0;
      mem_ready = 0; mem_recv_valid = 0; mem_recv_data = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_aL = 0;
      repeat (2) next_cycle();
      rst_aL = 1;
      m_last_ifu = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_aL = 0;
      ifu_req_valid = 1; lsu_req_valid = 1; mem_recv_valid = 1; mem_recv_data = 64'hFFFF_0000_FFFF_0000;
      @(negedge clk);
      checks++; if (ifu_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ifu_ready: got %b expected 0", ifu_req_ready); end
      checks++; if (lsu_req_ready !== 1'b0) begin errors++; $display("FAIL reset_lsu_ready: got %b expected 0", lsu_req_ready); end
      checks++; if (mem_send_en !== 1'b0) begin errors++; $display("FAIL reset_send_en: got %b expected 0", mem_send_en); end
      checks++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %b expected 00", {ifu_resp_valid, lsu_resp_valid}); end
      checks++; if (resp_data !== 64'h0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
      checks++; if ({mem_send_lsu_aL_ifu_aH, mem_send_addr, mem_send_size, mem_send_data} !== '0) begin errors++; $display("FAIL reset_send_fields: got %h/%h/%h expected 0", mem_send_addr, mem_send_size, mem_send_data); end
      do_reset();
   endtask

   task automatic test_ifu_only();
      ifu_req_valid = 1; ifu_req_addr = 32'h0000_1040;
      @(negedge clk);
      checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin errors++; $display("FAIL ifu_only_ready: got %b expected 10", {ifu_req_ready, lsu_req_ready}); end
      next_cycle(); ifu_req_valid = 0;
      @(negedge clk);
      checks++; if ({mem_send_en, mem_send_lsu_aL_ifu_aH} !== 2'b11) begin errors++; $display("FAIL ifu_only_send: got %b expected 11", {mem_send_en, mem_send_lsu_aL_ifu_aH}); end
      checks++; if (mem_send_addr !== 32'h1040 || mem_send_size !== 3'b0 || mem_send_data !== 32'h0) begin errors++; $display("FAIL ifu_only_fields: got %h/%h/%h expected 1040/0/0", mem_send_addr, mem_send_size, mem_send_data); end
      next_cycle(); mem_ready = 1;
      @(negedge clk);
      checks++; if (mem_send_en !== 1'b1) begin errors++; $display("FAIL ifu_only_accept: got %b expected 1", mem_send_en); end
      next_cycle(); mem_ready = 0;
      repeat (2) begin
         @(negedge clk);
         checks++; if ({mem_send_en, ifu_resp_valid} !== 2'b00) begin errors++; $display("FAIL ifu_only_wait: got %b expected 00", {mem_send_en, ifu_resp_valid}); end
         next_cycle();
      end
      mem_recv_valid = 1; mem_recv_data = 64'hDEAD_BEEF_0000_0013;
      @(negedge clk);
      checks++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b10) begin errors++; $display("FAIL ifu_only_resp: got %b expected 10", {ifu_resp_valid, lsu_resp_valid}); end
      checks++; if (resp_data !== 64'hDEAD_BEEF_0000_0013) begin errors++; $display("FAIL ifu_only_data: got %h expected deadbeef00000013", resp_data); end
      next_cycle();
      @(negedge clk);
      checks++; if ({ifu_resp_valid, mem_send_en} !== 2'b00) begin errors++; $display("FAIL ifu_only_stray_recv: got %b expected 00", {ifu_resp_valid, mem_send_en}); end
      next_cycle(); mem_recv_valid = 0;
      m_last_ifu = 1'b1;
   endtask

   task automatic test_store();
      lsu_req_valid = 1; lsu_req_is_st = 1; lsu_req_addr = 32'h2000; lsu_req_size = 3'b100; lsu_req_data = 32'h1234_5678;
      @(negedge clk);
      checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("FAIL store_ready: got %b expected 1", lsu_req_ready); end
      next_cycle(); lsu_req_valid = 0; mem_ready = 1;
      @(negedge clk);
      checks++; if ({mem_send_en, mem_send_lsu_aL_ifu_aH} !== 2'b10) begin errors++; $display("FAIL store_send: got %b expected 10", {mem_send_en, mem_send_lsu_aL_ifu_aH}); end
      checks++; if (mem_send_addr !== 32'h2000 || mem_send_size !== 3'b100 || mem_send_data !== 32'h1234_5678) begin errors++; $display("FAIL store_fields: got %h/%h/%h expected 2000/4/12345678", mem_send_addr, mem_send_size, mem_send_data); end
      next_cycle(); mem_ready = 0; mem_recv_valid = 1; lsu_req_is_st = 0;
      @(negedge clk);
      checks++; if ({mem_send_en, lsu_resp_valid, ifu_resp_valid} !== 3'b000) begin errors++; $display("FAIL store_after: got %b expected 000", {mem_send_en, lsu_resp_valid, ifu_resp_valid}); end
      next_cycle(); mem_recv_valid = 0;
      m_last_ifu = 1'b0;
   endtask

   task automatic test_flush_wait();
      ifu_req_valid = 1; ifu_req_addr = 32'h0000_3000;
      next_cycle(); ifu_req_valid = 0; mem_ready = 1;
      next_cycle(); mem_ready = 0;
      next_cycle(); ifu_flush = 1;
      next_cycle(); ifu_flush = 0;
      repeat (2) next_cycle();
      mem_recv_valid = 1; mem_recv_data = 64'h1111_2222_3333_4444;
      @(negedge clk);
      checks++; if (ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL flush_wait_drop: got %b expected 0", ifu_resp_valid); end
      next_cycle(); mem_recv_valid = 0; ifu_req_valid = 1; ifu_flush = 1; ifu_req_addr = 32'h0000_3040;
      @(negedge clk);
      checks++; if (ifu_req_ready !== 1'b1) begin errors++; $display("FAIL flush_wait_regrant: got %b expected 1", ifu_req_ready); end
      next_cycle(); ifu_req_valid = 0; ifu_flush = 0; mem_ready = 1;
      next_cycle(); mem_ready = 0; mem_recv_valid = 1;
      @(negedge clk);
      checks++; if (ifu_resp_valid !== 1'b1) begin errors++; $display("FAIL flush_wait_next_resp: got %b expected 1", ifu_resp_valid); end
      next_cycle(); mem_recv_valid = 0;
      m_last_ifu = 1'b1;
   endtask

   task automatic test_conflict();
      logic [2:0] exp_ifu;
      exp_ifu = 3'b010;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         ifu_req_valid = 1; lsu_req_valid = 1; lsu_req_is_st = 0; lsu_req_addr = 32'h4000 + i;
         @(negedge clk);
         checks++; if ({ifu_req_ready, lsu_req_ready} !== {exp_ifu[i], ~exp_ifu[i]}) begin errors++; $display("FAIL conflict_grant%0d: got %b expected %b", i, {ifu_req_ready, lsu_req_ready}, {exp_ifu[i], ~exp_ifu[i]}); end
         next_cycle(); mem_ready = 1;
         @(negedge clk);
         checks++; if (mem_send_lsu_aL_ifu_aH !== exp_ifu[i]) begin errors++; $display("FAIL conflict_owner%0d: got %b expected %b", i, mem_send_lsu_aL_ifu_aH, exp_ifu[i]); end
         next_cycle(); mem_ready = 0; ifu_req_valid = 0; lsu_req_valid = 0; mem_recv_valid = 1;
         next_cycle(); mem_recv_valid = 0;
         m_last_ifu = exp_ifu[i];
      end
   endtask

   task automatic test_backpressure_reset();
      logic [31:0] a;
      a = $urandom;
      lsu_req_valid = 1; lsu_req_is_st = 0; lsu_req_addr = a; lsu_req_size = 3'b010; lsu_req_data = 32'hA5A5_0F0F;
      next_cycle(); lsu_req_addr = ~a;
      for (int c = 1; c <= 4; c++) begin
         if (c == 3) begin rst_aL = 0; mem_recv_valid = 1; mem_recv_data = 64'h5555; end
         @(negedge clk);
         if (c < 3) begin
            checks++; if (mem_send_en !== 1'b1 || mem_send_addr !== a || mem_send_size !== 3'b010 || mem_send_data !== 32'hA5A5_0F0F) begin errors++; $display("FAIL bp_stable%0d: got %b/%h/%h/%h", c, mem_send_en, mem_send_addr, mem_send_size, mem_send_data); end
         end else begin
            checks++; if ({mem_send_en, lsu_req_ready, mem_send_addr, mem_send_size, mem_send_data, resp_data} !== '0) begin errors++; $display("FAIL bp_reset%0d: got en=%b rdy=%b addr=%h data=%h resp=%h expected all 0", c, mem_send_en, lsu_req_ready, mem_send_addr, mem_send_data, resp_data); end
         end
         next_cycle();
      end
      clear_inputs(); rst_aL = 1; m_last_ifu = 1'b1;
      mem_recv_valid = 1;
      @(negedge clk);
      checks++; if ({ifu_resp_valid, lsu_resp_valid, mem_send_en} !== 3'b000) begin errors++; $display("FAIL bp_stray_recv: got %b expected 000", {ifu_resp_valid, lsu_resp_valid, mem_send_en}); end
      next_cycle(); mem_recv_valid = 0;
   endtask

   task automatic test_random(input int n);
      for (int t = 0; t < n; t++) begin
         logic [1:0]  r;
         int          mode, stall, lat;
         bit          win_ifu, st, dropped, fl_acc, is_store;
         logic [2:0]  sz;
         logic [31:0] ia, la, ld, e_addr, e_data;
         logic [2:0]  e_size;
         logic [63:0] rd;
         r = 2'($urandom_range(1, 3));
         ia = $urandom; la = $urandom; ld = $urandom; st = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 2))
            0: sz = 3'b001;
            1: sz = 3'b010;
            default: sz = 3'b100;
         endcase
         mode = $urandom_range(0, 3); stall = $urandom_range(0, 3); lat = $urandom_range(0, 3);
         win_ifu  = (r == 2'b11) ? !m_last_ifu : r[1];
         is_store = !win_ifu && st;
         e_addr = win_ifu ? ia : la;
         e_size = win_ifu ? 3'b000 : sz;
         e_data = win_ifu ? 32'h0 : ld;
         ifu_req_valid = r[1]; lsu_req_valid = r[0];
         ifu_req_addr = ia; lsu_req_addr = la; lsu_req_is_st = st; lsu_req_size = sz; lsu_req_data = ld;
         mem_recv_valid = 1'($urandom_range(0, 1)); ifu_flush = 1'($urandom_range(0, 1));
         @(negedge clk);
         checks++; if ({ifu_req_ready, lsu_req_ready} !== {win_ifu, ~win_ifu}) begin errors++; $display("FAIL rnd%0d_grant: got %b expected %b", t, {ifu_req_ready, lsu_req_ready}, {win_ifu, ~win_ifu}); end
         checks++; if ({mem_send_en, ifu_resp_valid, lsu_resp_valid} !== 3'b000) begin errors++; $display("FAIL rnd%0d_idle: got %b expected 000", t, {mem_send_en, ifu_resp_valid, lsu_resp_valid}); end
         next_cycle();
         m_last_ifu = win_ifu; mem_recv_valid = 0; ifu_flush = 0;
         if (win_ifu && mode == 1) begin
            mem_ready = 0; ifu_flush = 1;
            @(negedge clk);
            checks++; if (mem_send_en !== 1'b1) begin errors++; $display("FAIL rnd%0d_flush_send: got %b expected 1", t, mem_send_en); end
            next_cycle(); ifu_flush = 0; ifu_req_valid = 0; lsu_req_valid = 0;
         end else begin
            for (int s = 0; s < stall; s++) begin
               mem_ready = 0; mem_recv_valid = 1'($urandom_range(0, 1));
               ifu_flush = win_ifu ? 1'b0 : 1'($urandom_range(0, 1));
               @(negedge clk);
               checks++; if ({mem_send_en, mem_send_lsu_aL_ifu_aH, mem_send_addr, mem_send_size, mem_send_data} !== {1'b1, win_ifu, e_addr, e_size, e_data}) begin errors++; $display("FAIL rnd%0d_stall: got %b/%b/%h/%h/%h expected 1/%b/%h/%h/%h", t, mem_send_en, mem_send_lsu_aL_ifu_aH, mem_send_addr, mem_send_size, mem_send_data, win_ifu, e_addr, e_size, e_data); end
               checks++; if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid} !== 4'b0000) begin errors++; $display("FAIL rnd%0d_stall_quiet: got %b expected 0000", t, {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid}); end
               next_cycle();
            end
            fl_acc = win_ifu && mode == 2 && lat == 0;
            mem_ready = 1; mem_recv_valid = 0;
            ifu_flush = win_ifu ? fl_acc : 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++; if ({mem_send_en, mem_send_addr} !== {1'b1, e_addr}) begin errors++; $display("FAIL rnd%0d_accept: got %b/%h expected 1/%h", t, mem_send_en, mem_send_addr, e_addr); end
            next_cycle();
            mem_ready = 0; ifu_flush = 0; ifu_req_valid = 0; lsu_req_valid = 0;
            dropped = fl_acc;
            if (!is_store) begin
               for (int w = 0; w < lat; w++) begin
                  ifu_flush = win_ifu ? (mode == 2 && w == 0) : 1'($urandom_range(0, 1));
                  if (win_ifu && ifu_flush) dropped = 1;
                  @(negedge clk);
                  checks++; if ({mem_send_en, ifu_resp_valid, lsu_resp_valid} !== 3'b000) begin errors++; $display("FAIL rnd%0d_wait: got %b expected 000", t, {mem_send_en, ifu_resp_valid, lsu_resp_valid}); end
                  next_cycle();
               end
               rd = {$urandom, $urandom};
               mem_recv_valid = 1; mem_recv_data = rd;
               ifu_flush = win_ifu ? (mode == 3) : 1'($urandom_range(0, 1));
               if (win_ifu && mode == 3) dropped = 1;
               @(negedge clk);
               checks++; if ({ifu_resp_valid, lsu_resp_valid} !== {win_ifu && !dropped, ~win_ifu}) begin errors++; $display("FAIL rnd%0d_resp: got %b expected %b", t, {ifu_resp_valid, lsu_resp_valid}, {win_ifu && !dropped, ~win_ifu}); end
               checks++; if (resp_data !== rd) begin errors++; $display("FAIL rnd%0d_resp_data: got %h expected %h", t, resp_data, rd); end
               next_cycle(); mem_recv_valid = 0; ifu_flush = 0;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_ifu_only();
      test_store();
      test_flush_wait();
      test_conflict();
      test_backpressure_reset();
      test_random(300);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
